eth_pkt_gen: RTL
================

// Module: eth_pkt_gen
// PURPOSE
//  Parametrised Ethernet test-frame generator driving the MAC transmit AXI-Stream port (tx_axis_mac_*).
//  Sends programmable-length frames with a configurable header, payload pattern, frame count and
//  inter-frame gap, plus start/stop control and status. Replaces the fixed 64-byte button-triggered sender.
// PARAMETERS
//  LEN_W    11    width of length fields and of the internal byte index
//  MIN_LEN  60    minimum frame length in bytes, FCS excluded; shorter requests are raised to this
//  MAX_LEN  1514  maximum frame length in bytes, FCS excluded; longer requests are cut to this
//  CNT_W    16    width of cfg_count and of the frame sequence number
//  GAP_W    16    width of cfg_gap
// PORTS
//  clk_mac             in   1      MAC clock; the only clock
//  rst                 in   1      synchronous, active-high reset
//  start               in   1      one-cycle pulse: latch cfg_*, begin a burst (ignored while busy)
//  stop                in   1      pulse: end the burst after the frame in flight
//  cfg_dst_mac         in   48     destination MAC, sent MSB byte first
//  cfg_src_mac         in   48     source MAC, sent MSB byte first
//  cfg_ethertype       in   16     EtherType, sent MSB byte first
//  cfg_len             in   LEN_W  frame length in bytes, FCS excluded
//  cfg_mode            in   2      payload: 0=INCR 1=FILL 2=PRBS 3=SEQ
//  cfg_fill            in   8      fill byte for FILL mode
//  cfg_count           in   CNT_W  frames per burst; 0 = run until stop
//  cfg_gap             in   GAP_W  idle cycles between frames
//  tx_axis_mac_tdata   out  8      frame byte
//  tx_axis_mac_tvalid  out  1      byte valid
//  tx_axis_mac_tlast   out  1      last byte of the frame
//  tx_axis_mac_tready  in   1      MAC accepts the byte
//  busy                out  1      high from start acceptance until the burst ends
//  done                out  1      one-cycle pulse when the burst ends
//  frames_sent         out  32     frames completed since reset; wraps around
// BEHAVIOUR
//  - Reset: state IDLE. tvalid, tlast, busy and done are 0. tdata is 0. frames_sent is 0. Sequence number is 0.
//  - All outputs are registered.
//  - FSM states: IDLE -> SEND -> GAP -> SEND ... -> IDLE.
//  - IDLE: on start, latch every cfg_* input and set busy. On the next cycle, tvalid=1 with byte 0.
//    That is 1 cycle of latency. Config changes during a burst have no effect.
//  - Length: L = clamp(cfg_len, MIN_LEN, MAX_LEN).
//  - Byte i for i in 0..L-1:
//    - bytes 0-5: dst MAC; bytes 6-11: src MAC; bytes 12-13: EtherType.
//    - payload byte i >= 14 depends on mode:
//      - INCR: i[7:0]
//      - FILL: cfg_fill
//      - PRBS: LFSR x^8+x^6+x^5+x^4+1, seeded 8'hFF at the start of each frame, stepped once per accepted payload byte
//      - SEQ: bytes 14-17 are the frame sequence number, zero-extended to 32 bits, MSB first; then i[7:0]
//  - AXIS rules:
//    - tdata and tlast hold stable while tvalid && !tready.
//    - The byte index advances only on tvalid && tready.
//    - A new byte is presented in the same cycle as the accept, so there are no bubbles inside a frame.
//    - tlast is 1 only on byte L-1.
//    - tvalid never drops inside a frame.
//  - End of frame (last byte accepted):
//    - frames_sent increments and the sequence number increments.
//    - If cfg_count != 0 and frames in this burst == cfg_count: go to IDLE, pulse done, clear busy.
//    - Otherwise, if a stop is pending: same as above.
//    - Otherwise: go to GAP.
//  - GAP: tvalid=0 for exactly cfg_gap cycles, then SEND with byte 0.
//    With cfg_gap=0 the next frame's byte 0 is presented the cycle after the last accept.
//  - stop: in SEND, it is latched as pending and the frame in flight completes (never truncated).
//    In GAP, go to IDLE next cycle and pulse done. In IDLE, no effect.
//  - start and stop in the same IDLE cycle: start wins, stop is ignored.
//  - Last-byte accept and stop in the same cycle: the burst ends (IDLE, done).
//  - rst mid-frame: tvalid drops next edge and the frame is abandoned. The MAC side is reset together with this block.
//  - The sequence number is CNT_W bits and wraps around. frames_sent wraps from 2^32-1 to 0.
// STRUCTURE
//  - Shared package eth_pkg: payload mode constants, header byte offsets (DST=0, SRC=6, TYPE=12, PAYLOAD=14), LFSR polynomial and seed.
//  - One sub-module, eth_lfsr8: 8-bit Fibonacci LFSR with load/step inputs.
//  - Header mux, byte counter, gap counter and FSM stay in the top.
// TESTING
//  1. INCR, len=64, count=1, tready=1, dst=FF..FF, src=0, type=EBEB
//     -> bytes FF x6, 00 x6, EB EB, then 0E..3F; tlast on byte 63; done 1 cycle later; frames_sent=1.
//  2. len=20 -> 60 bytes sent. len=2000 -> 1514 bytes sent.
//  3. FILL A5, count=3, gap=10, random tready
//     -> 3 frames; exactly 10 idle cycles between each; tdata/tlast stable while stalled.
//  4. PRBS, count=2 -> payload byte 14 = FF followed by the reference LFSR sequence; identical payload in both frames.
//  5. SEQ, count=0, gap=0; stop on byte 30 of frame 5
//     -> frame 5 completes; seq bytes 00000000..00000004 across frames; done pulses; busy falls.
//  6. Assert rst on byte 10 -> tvalid=0 next cycle; all outputs at reset values; start during busy is ignored.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet test-frame generator: payload modes,
// header layout, PRBS polynomial and small byte-select helpers.
package eth_pkg;

  localparam logic [1:0] MODE_INCR = 2'd0;
  localparam logic [1:0] MODE_FILL = 2'd1;
  localparam logic [1:0] MODE_PRBS = 2'd2;
  localparam logic [1:0] MODE_SEQ  = 2'd3;

  localparam int unsigned OFF_DST     = 0;
  localparam int unsigned OFF_SRC     = OFF_DST + 6;
  localparam int unsigned OFF_TYPE    = OFF_SRC + 6;
  localparam int unsigned OFF_PAYLOAD = OFF_TYPE + 2;
  localparam int unsigned OFF_SEQ_END = OFF_PAYLOAD + 4;

  // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'hFF;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] ethertype;
    logic [1:0]  mode;
    logic [7:0]  fill;
  } frame_cfg_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

  // Header byte idx (0..13), dst/src/type each sent MSB byte first
  function automatic logic [7:0] hdr_byte(input frame_cfg_t cfg, input logic [3:0] idx);
    logic [111:0] hdr;
    hdr = {cfg.dst, cfg.src, cfg.ethertype} << {idx, 3'b000};
    return hdr[111:104];
  endfunction

  function automatic logic [7:0] seq_byte(input logic [31:0] seq, input logic [1:0] k);
    logic [31:0] s;
    s = seq << {k, 3'b000};
    return s[31:24];
  endfunction

endpackage

// File: rtl/eth_pkt_gen_if.sv
// Byte-wide AXI-Stream transmit link between the frame generator and the MAC.
interface eth_pkt_gen_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_lfsr8.sv
// 8-bit Fibonacci LFSR for the PRBS payload; load has priority over step.
module eth_lfsr8
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [7:0] q,
  output logic [7:0] q_next_c
);

  assign q_next_c = lfsr_step(q);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= q_next_c;
    end
  end

endmodule

// File: rtl/eth_pkt_gen.sv
// Ethernet test-frame generator: bursts of programmable-length frames with a
// configurable header, payload pattern, frame count and inter-frame gap.
module eth_pkt_gen
  import eth_pkg::*;
#(
  parameter int unsigned LEN_W   = 11,
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1514,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned GAP_W   = 16
) (
  input  logic              clk_mac,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [47:0]       cfg_dst_mac,
  input  logic [47:0]       cfg_src_mac,
  input  logic [15:0]       cfg_ethertype,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [1:0]        cfg_mode,
  input  logic [7:0]        cfg_fill,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [GAP_W-1:0]  cfg_gap,
  eth_pkt_gen_if.master     tx_axis_mac,
  output logic              busy,
  output logic              done,
  output logic [31:0]       frames_sent
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  frame_cfg_t       cfg_q, cfg_d, cfg_in;
  logic [LEN_W-1:0] len_q, len_d, len_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] seq_q, seq_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             stop_pend_q, stop_pend_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      frames_q, frames_d;

  logic             accept_c;
  logic [LEN_W-1:0] nxt_idx_c;
  logic [CNT_W-1:0] burst_inc_c;
  logic             burst_end_c;
  logic [7:0]       nxt_byte_c;
  logic [7:0]       lfsr_q, lfsr_nxt_c;
  logic             lfsr_load_c;

  assign tx_axis_mac.tdata  = tdata_q;
  assign tx_axis_mac.tvalid = tvalid_q;
  assign tx_axis_mac.tlast  = tlast_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = frames_q;

  assign cfg_in = '{dst: cfg_dst_mac, src: cfg_src_mac, ethertype: cfg_ethertype,
                    mode: cfg_mode, fill: cfg_fill};

  assign accept_c    = tvalid_q & tx_axis_mac.tready;
  assign nxt_idx_c   = idx_q + LEN_W'(1);
  assign burst_inc_c = burst_q + CNT_W'(1);
  assign burst_end_c = ((cnt_q != '0) && (burst_inc_c == cnt_q)) || stop_pend_q || stop;

  // Seed is held through the header so byte 14 always starts at the seed
  assign lfsr_load_c = !((state_q == ST_SEND) && (idx_q >= LEN_W'(OFF_PAYLOAD)));

  eth_lfsr8 u_lfsr (
    .clk      (clk_mac),
    .rst      (rst),
    .load     (lfsr_load_c),
    .step     (accept_c),
    .q        (lfsr_q),
    .q_next_c (lfsr_nxt_c)
  );

  // Requested length clamped into the legal frame range
  always_comb begin
    len_in = cfg_len;
    if (cfg_len < LEN_W'(MIN_LEN)) begin
      len_in = LEN_W'(MIN_LEN);
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      len_in = LEN_W'(MAX_LEN);
    end
  end

  // Byte that follows the one currently presented
  always_comb begin
    nxt_byte_c = 8'h00;
    if (nxt_idx_c < LEN_W'(OFF_PAYLOAD)) begin
      nxt_byte_c = hdr_byte(cfg_q, nxt_idx_c[3:0]);
    end else begin
      case (cfg_q.mode)
        MODE_INCR: nxt_byte_c = nxt_idx_c[7:0];
        MODE_FILL: nxt_byte_c = cfg_q.fill;
        MODE_PRBS: nxt_byte_c = (nxt_idx_c == LEN_W'(OFF_PAYLOAD)) ? lfsr_q : lfsr_nxt_c;
        default: begin
          if (nxt_idx_c < LEN_W'(OFF_SEQ_END)) begin
            nxt_byte_c = seq_byte(32'(seq_q), 2'(nxt_idx_c - LEN_W'(OFF_PAYLOAD)));
          end else begin
            nxt_byte_c = nxt_idx_c[7:0];
          end
        end
      endcase
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    burst_d     = burst_q;
    seq_d       = seq_q;
    idx_d       = idx_q;
    stop_pend_d = stop_pend_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    frames_d    = frames_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d       = cfg_in;
          len_d       = len_in;
          cnt_d       = cfg_count;
          gap_d       = cfg_gap;
          burst_d     = '0;
          idx_d       = '0;
          stop_pend_d = 1'b0;
          tdata_d     = hdr_byte(cfg_in, 4'(OFF_DST));
          tvalid_d    = 1'b1;
          tlast_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (accept_c) begin
          if (tlast_q) begin
            frames_d = frames_q + 32'd1;
            seq_d    = seq_q + CNT_W'(1);
            burst_d  = burst_inc_c;
            idx_d    = '0;
            tlast_d  = 1'b0;
            if (burst_end_c) begin
              tvalid_d    = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
              state_d     = ST_IDLE;
            end else if (gap_q == '0) begin
              tdata_d = hdr_byte(cfg_q, 4'(OFF_DST));
            end else begin
              tvalid_d  = 1'b0;
              gap_cnt_d = gap_q;
              state_d   = ST_GAP;
            end
          end else begin
            idx_d   = nxt_idx_c;
            tdata_d = nxt_byte_c;
            tlast_d = (nxt_idx_c == len_q - LEN_W'(1));
          end
        end
      end

      ST_GAP: begin
        if (stop) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          idx_d    = '0;
          tdata_d  = hdr_byte(cfg_q, 4'(OFF_DST));
          tvalid_d = 1'b1;
          state_d  = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_mac) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      burst_q     <= '0;
      seq_q       <= '0;
      idx_q       <= '0;
      stop_pend_q <= 1'b0;
      tdata_q     <= 8'h00;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frames_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      burst_q     <= burst_d;
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      stop_pend_q <= stop_pend_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frames_q    <= frames_d;
    end
  end

endmodule
